// File: rtl/mem_load_arbiter_pkg.sv
// Shared types for the program-RAM port arbiter: FSM state encoding and CPU access size codes.
// No logic; latency n/a.
// Backpressure n/a.
package mem_load_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_byte_en.sv
// Decodes CPU access size and byte offset into a 4-lane write mask.
// Latency: combinational.
// Backpressure: none.
module mem_byte_en
    import mem_load_arbiter_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] offset,
    output logic [3:0] byte_en
);

    always_comb begin
        byte_en = BE_WORD;
        case (size)
            SIZE_BYTE: byte_en = 4'b0001 << offset;
            SIZE_HALF: byte_en = 4'b0011 << offset;
            default:   byte_en = BE_WORD;
        endcase
    end

endmodule

// File: rtl/mem_load_arbiter.sv
// Shares the program-RAM data port between the CPU dBus and a loader; optional loader readback under MEM_ARB_READBACK_EN.
// Latency: RAM command combinational from owner, read response 1 cycle; ld_req rise->ld_gnt 2 cycles, fall->cpu ready 2 cycles.
// Backpressure: cpu_cmd_ready only in IDLE, ld_ready only in LOAD; cpu_hold covers the whole session.
module mem_load_arbiter
    import mem_load_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 11,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 cpu_cmd_valid,
    output logic                 cpu_cmd_ready,
    input  logic                 cpu_cmd_wr,
    input  logic [ADDR_BITS-1:0] cpu_cmd_addr,
    input  logic [1:0]           cpu_cmd_size,
    input  logic [31:0]          cpu_cmd_wdata,
    output logic                 cpu_rsp_valid,
    output logic [31:0]          cpu_rsp_data,
    output logic                 cpu_hold,

    input  logic                 ld_req,
    output logic                 ld_gnt,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic                 ld_wr,
    input  logic [ADDR_BITS-3:0] ld_addr,
    input  logic [31:0]          ld_wdata,
    output logic                 ld_rsp_valid,
    output logic [31:0]          ld_rsp_data,
    output logic [CNT_BITS-1:0]  ld_count,

    output logic                 ram_en,
    output logic [3:0]           ram_we,
    output logic [ADDR_BITS-3:0] ram_addr,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata
);

    arb_state_t          state_q, state_d;
    logic                cpu_rd_pend_q;
    logic [CNT_BITS-1:0] ld_count_q;
    logic [3:0]          cpu_be;
    logic                cpu_acc;
    logic                ld_wr_acc;
    logic                ld_rd_ram;

    mem_byte_en u_byte_en (
        .size    (cpu_cmd_size),
        .offset  (cpu_cmd_addr[1:0]),
        .byte_en (cpu_be)
    );

    assign cpu_acc   = (state_q == ST_IDLE) && cpu_cmd_valid;
    assign ld_wr_acc = (state_q == ST_LOAD) && ld_valid && ld_wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A read accepted in the last IDLE cycle returns during DRAIN
                // without touching the port, so one cycle always suffices.
                if (!ld_req) state_d = ST_IDLE;
                else         state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!ld_req) state_d = ST_RELEASE;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_cmd_ready = 1'b0;
        cpu_hold      = 1'b0;
        ld_gnt        = 1'b0;
        ld_ready      = 1'b0;
        ram_en        = 1'b0;
        ram_we        = BE_NONE;
        ram_addr      = cpu_cmd_addr[ADDR_BITS-1:2];
        ram_wdata     = cpu_cmd_wdata;
        case (state_q)
            ST_IDLE: begin
                cpu_cmd_ready = 1'b1;
                ram_en        = cpu_cmd_valid;
                ram_we        = (cpu_cmd_valid && cpu_cmd_wr) ? cpu_be : BE_NONE;
            end
            ST_DRAIN: begin
                cpu_hold = 1'b1;
            end
            ST_LOAD: begin
                cpu_hold  = 1'b1;
                ld_gnt    = 1'b1;
                ld_ready  = 1'b1;
                ram_en    = ld_wr_acc || ld_rd_ram;
                ram_we    = ld_wr_acc ? BE_WORD : BE_NONE;
                ram_addr  = ld_addr;
                ram_wdata = ld_wdata;
            end
            default: begin
                cpu_hold = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rd_pend_q <= 1'b0;
        end else begin
            cpu_rd_pend_q <= cpu_acc && !cpu_cmd_wr;
        end
    end

    assign cpu_rsp_valid = cpu_rd_pend_q;
    assign cpu_rsp_data  = ram_rdata;

    // Count restarts when a session begins and holds its value after it ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_count_q <= '0;
        end else if ((state_q == ST_IDLE) && ld_req) begin
            ld_count_q <= '0;
        end else if (ld_wr_acc && !(&ld_count_q)) begin
            ld_count_q <= ld_count_q + 1'b1;
        end
    end

    assign ld_count = ld_count_q;

`ifdef MEM_ARB_READBACK_EN
    logic ld_rd_pend_q;

    assign ld_rd_ram = (state_q == ST_LOAD) && ld_valid && !ld_wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_rd_pend_q <= 1'b0;
        end else begin
            ld_rd_pend_q <= ld_rd_ram;
        end
    end

    assign ld_rsp_valid = ld_rd_pend_q;
    assign ld_rsp_data  = ram_rdata;
`else
    // Loader reads are still handshaken in LOAD but never reach the RAM.
    assign ld_rd_ram    = 1'b0;
    assign ld_rsp_valid = 1'b0;
    assign ld_rsp_data  = '0;
`endif

endmodule

// File: tb/tb_mem_load_arbiter.sv
// Bench for mem_load_arbiter: behavioural RAM, CPU vector table, scoreboarded responses, session sequences.
module tb_mem_load_arbiter;

    logic        clk;
    logic        reset_n;
    logic        cpu_cmd_valid, cpu_cmd_ready, cpu_cmd_wr;
    logic [10:0] cpu_cmd_addr;
    logic [1:0]  cpu_cmd_size;
    logic [31:0] cpu_cmd_wdata;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_data;
    logic        cpu_hold;
    logic        ld_req, ld_gnt, ld_valid, ld_ready, ld_wr;
    logic [8:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_rsp_valid;
    logic [31:0] ld_rsp_data;
    logic [15:0] ld_count;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    mem_load_arbiter #(.ADDR_BITS(11), .CNT_BITS(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready), .cpu_cmd_wr(cpu_cmd_wr),
        .cpu_cmd_addr(cpu_cmd_addr), .cpu_cmd_size(cpu_cmd_size), .cpu_cmd_wdata(cpu_cmd_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data), .cpu_hold(cpu_hold),
        .ld_req(ld_req), .ld_gnt(ld_gnt), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wr(ld_wr),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
        .ld_count(ld_count),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t cpu_q[$];
    rsp_t mon_e;

    always @(negedge clk) begin
        if (reset_n) begin
            if (cpu_rsp_valid) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = cpu_q.pop_front();
                    check("cpu_rsp_data", cpu_rsp_data, mon_e.data);
                    check("cpu_rsp_cycle", cyc, mon_e.due);
                end
            end else if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
                check("cpu_rsp_missing", 32'd0, 32'd1);
                void'(cpu_q.pop_front());
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [10:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  exp_we;
        logic [8:0]  exp_waddr;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input logic [31:0] d);
        rsp_t t;
        t.data = d;
        t.due  = cyc + 1;
        cpu_q.push_back(t);
    endtask

    task automatic cpu_read(input logic [10:0] a, input logic [31:0] exp);
        step();
        cpu_cmd_valid = 1'b1; cpu_cmd_wr = 1'b0; cpu_cmd_addr = a; cpu_cmd_size = 2'd2;
        push_rsp(exp);
        step();
        cpu_cmd_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 11'h006, 2'd0, 32'h00AB0000, 4'b0100, 9'd1, 32'h0};
        vecs[1]  = '{1'b0, 11'h004, 2'd2, 32'h0,        4'b0000, 9'd1, 32'h00AB0000};
        vecs[2]  = '{1'b1, 11'h00A, 2'd1, 32'hBEEFBEEF, 4'b1100, 9'd2, 32'h0};
        vecs[3]  = '{1'b1, 11'h00C, 2'd2, 32'h11223344, 4'b1111, 9'd3, 32'h0};
        vecs[4]  = '{1'b1, 11'h010, 2'd3, 32'hCAFEF00D, 4'b1111, 9'd4, 32'h0};
        vecs[5]  = '{1'b1, 11'h00F, 2'd0, 32'h77777777, 4'b1000, 9'd3, 32'h0};
        vecs[6]  = '{1'b0, 11'h008, 2'd2, 32'h0,        4'b0000, 9'd2, 32'hBEEF0000};
        vecs[7]  = '{1'b0, 11'h00C, 2'd2, 32'h0,        4'b0000, 9'd3, 32'h77223344};
        vecs[8]  = '{1'b0, 11'h010, 2'd2, 32'h0,        4'b0000, 9'd4, 32'hCAFEF00D};
        vecs[9]  = '{1'b1, 11'h000, 2'd1, 32'hABCDABCD, 4'b0011, 9'd0, 32'h0};
        vecs[10] = '{1'b0, 11'h003, 2'd0, 32'h0,        4'b0000, 9'd0, 32'h0000ABCD};
        vecs[11] = '{1'b0, 11'h005, 2'd1, 32'h0,        4'b0000, 9'd1, 32'h00AB0000};
        vecs[12] = '{1'b1, 11'h011, 2'd0, 32'h5A5A5A5A, 4'b0010, 9'd4, 32'h0};
        vecs[13] = '{1'b0, 11'h010, 2'd2, 32'h0,        4'b0000, 9'd4, 32'hCAFE5A0D};

        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        ram_rdata = 32'h0;
        reset_n = 1'b0;
        cpu_cmd_valid = 1'b0; cpu_cmd_wr = 1'b0; cpu_cmd_addr = '0; cpu_cmd_size = '0; cpu_cmd_wdata = '0;
        ld_req = 1'b0; ld_valid = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_wdata = '0;

        repeat (2) @(negedge clk);
        check("rst_cpu_cmd_ready", cpu_cmd_ready, 1);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_ld_gnt", ld_gnt, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_cpu_rsp_valid", cpu_rsp_valid, 0);
        check("rst_ld_rsp_valid", ld_rsp_valid, 0);
        check("rst_ld_count", ld_count, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        #2 reset_n = 1'b1;

        // CPU traffic in IDLE
        for (int i = 0; i < 14; i++) begin
            step();
            cpu_cmd_valid = 1'b1;
            cpu_cmd_wr    = vecs[i].wr;
            cpu_cmd_addr  = vecs[i].addr;
            cpu_cmd_size  = vecs[i].size;
            cpu_cmd_wdata = vecs[i].wdata;
            if (!vecs[i].wr) push_rsp(vecs[i].exp_rdata);
            @(negedge clk);
            check("vec_ram_en", ram_en, 1);
            check("vec_ram_we", ram_we, vecs[i].exp_we);
            check("vec_ram_addr", ram_addr, vecs[i].exp_waddr);
            check("vec_cpu_cmd_ready", cpu_cmd_ready, 1);
            if (vecs[i].wr) check("vec_ram_wdata", ram_wdata, vecs[i].wdata);
        end
        step();
        cpu_cmd_valid = 1'b0;
        @(negedge clk);
        check("idle_ram_en", ram_en, 0);

        // CPU read in the cycle ld_req rises
        step();
        cpu_cmd_valid = 1'b1; cpu_cmd_wr = 1'b0; cpu_cmd_addr = 11'h00C; cpu_cmd_size = 2'd2;
        ld_req = 1'b1;
        push_rsp(32'h77223344);
        @(negedge clk);
        check("req_cpu_accept_en", ram_en, 1);
        check("req_cpu_ready", cpu_cmd_ready, 1);
        check("req_ld_gnt_c0", ld_gnt, 0);
        step();
        cpu_cmd_valid = 1'b0;
        @(negedge clk);
        check("drain_cpu_ready", cpu_cmd_ready, 0);
        check("drain_cpu_hold", cpu_hold, 1);
        check("drain_ld_gnt", ld_gnt, 0);
        check("drain_ram_en", ram_en, 0);
        check("drain_rsp_valid", cpu_rsp_valid, 1);
        check("drain_ld_count", ld_count, 0);
        step();
        @(negedge clk);
        check("load_ld_gnt", ld_gnt, 1);
        check("load_ld_ready", ld_ready, 1);
        check("load_cpu_hold", cpu_hold, 1);

        // Loader burst of word writes
        for (int i = 0; i < 10; i++) begin
            step();
            ld_valid = 1'b1; ld_wr = 1'b1; ld_addr = 9'(i); ld_wdata = 32'h1000 + 32'(i);
            @(negedge clk);
            check("ld_ram_en", ram_en, 1);
            check("ld_ram_we", ram_we, 4'b1111);
            check("ld_ram_addr", ram_addr, 9'(i));
            check("ld_ram_wdata", ram_wdata, 32'h1000 + 32'(i));
            check("ld_cpu_ready", cpu_cmd_ready, 0);
        end
        step();
        ld_valid = 1'b0;
        @(negedge clk);
        check("ld_count_10", ld_count, 10);
        check("ld_idle_ram_en", ram_en, 0);

        step();
        ld_valid = 1'b1; ld_wr = 1'b1; ld_addr = 9'd5; ld_wdata = 32'hDEADBEEF;
        step();
        ld_wr = 1'b0;
        @(negedge clk);
`ifdef MEM_ARB_READBACK_EN
        check("ld_rd_ram_en", ram_en, 1);
        check("ld_rd_ram_we", ram_we, 0);
        check("ld_rd_ram_addr", ram_addr, 5);
`else
        check("ld_rd_ram_en", ram_en, 0);
`endif
        step();
        ld_valid = 1'b0;
        @(negedge clk);
`ifdef MEM_ARB_READBACK_EN
        check("ld_rsp_valid", ld_rsp_valid, 1);
        check("ld_rsp_data", ld_rsp_data, 32'hDEADBEEF);
`else
        check("ld_rsp_valid", ld_rsp_valid, 0);
        check("ld_rsp_data", ld_rsp_data, 0);
`endif
        check("ld_count_11", ld_count, 11);
        step();
        @(negedge clk);
        check("ld_rsp_valid_pulse", ld_rsp_valid, 0);

        // Session release
        step();
        ld_req = 1'b0;
        @(negedge clk);
        check("rel0_ld_gnt", ld_gnt, 1);
        check("rel0_cpu_ready", cpu_cmd_ready, 0);
        step();
        @(negedge clk);
        check("rel1_ld_gnt", ld_gnt, 0);
        check("rel1_cpu_hold", cpu_hold, 1);
        check("rel1_cpu_ready", cpu_cmd_ready, 0);
        check("rel1_ram_en", ram_en, 0);
        step();
        @(negedge clk);
        check("rel2_cpu_ready", cpu_cmd_ready, 1);
        check("rel2_cpu_hold", cpu_hold, 0);
        check("rel2_ld_count_kept", ld_count, 11);

        cpu_read(11'h014, 32'hDEADBEEF);
        cpu_read(11'h024, 32'h00001009);
        cpu_read(11'h00C, 32'h00001003);

        // One-cycle ld_req pulse
        step();
        ld_req = 1'b1;
        @(negedge clk);
        check("pulse_c0_cpu_ready", cpu_cmd_ready, 1);
        step();
        ld_req = 1'b0;
        @(negedge clk);
        check("pulse_drain_hold", cpu_hold, 1);
        check("pulse_drain_ready", cpu_cmd_ready, 0);
        check("pulse_drain_gnt", ld_gnt, 0);
        check("pulse_count_clr", ld_count, 0);
        check("pulse_drain_ram_en", ram_en, 0);
        step();
        @(negedge clk);
        check("pulse_idle_ready", cpu_cmd_ready, 1);
        check("pulse_idle_hold", cpu_hold, 0);
        check("pulse_idle_gnt", ld_gnt, 0);
        step();
        @(negedge clk);
        check("pulse_after_gnt", ld_gnt, 0);

        // Asynchronous reset in the middle of LOAD
        step();
        ld_req = 1'b1;
        step();
        step();
        ld_valid = 1'b1; ld_wr = 1'b1; ld_addr = 9'd7; ld_wdata = 32'h77;
        @(negedge clk);
        check("rl_ld_gnt", ld_gnt, 1);
        check("rl_ram_en", ram_en, 1);
        step();
        ld_addr = 9'd8;
        @(negedge clk);
        check("rl_ld_count", ld_count, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rl_async_ld_gnt", ld_gnt, 0);
        check("rl_async_cpu_hold", cpu_hold, 0);
        check("rl_async_ram_en", ram_en, 0);
        check("rl_async_ld_ready", ld_ready, 0);
        check("rl_async_ld_count", ld_count, 0);
        ld_req = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("rl_post_cpu_ready", cpu_cmd_ready, 1);
        check("rl_post_ld_count", ld_count, 0);
        check("rl_post_ld_gnt", ld_gnt, 0);
        check("rl_post_cpu_hold", cpu_hold, 0);

        repeat (3) @(negedge clk);
        check("cpu_rsp_queue_empty", cpu_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_load_arbiter.md
# mem_load_arbiter

Arbitrates the single data/write port of the on-chip program RAM between the VexRiscv data bus and an external loader port used for quick RAM updates without re-synthesis. In normal operation the CPU owns the port. A loader session drains the CPU, holds it stalled, streams word writes (and optionally reads) into RAM, then returns ownership. The block sits between the CPU dBus address decode (RAM half only) and the byte-lane RAM arrays.

## Interface
- ADDR_BITS, 11: RAM byte-address width; word address is ADDR_BITS-2 bits.
- CNT_BITS, 16: width of the loader write counter.

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_cmd_valid  in  1  CPU RAM command
- cpu_cmd_ready  out  1  command accepted this cycle
- cpu_cmd_wr  in  1  1 = write
- cpu_cmd_addr  in  ADDR_BITS  byte address
- cpu_cmd_size  in  2  0 byte, 1 half, 2/3 word
- cpu_cmd_wdata  in  32  write data, lane-replicated by the CPU
- cpu_rsp_valid  out  1  read data valid
- cpu_rsp_data  out  32  read data
- cpu_hold  out  1  CPU must not issue new commands
- ld_req  in  1  session request, level
- ld_gnt  out  1  loader owns RAM port
- ld_valid  in  1  loader command
- ld_ready  out  1  loader command accepted
- ld_wr  in  1  1 = word write
- ld_addr  in  ADDR_BITS-2  word address
- ld_wdata  in  32  write data
- ld_rsp_valid  out  1  loader read data valid
- ld_rsp_data  out  32  loader read data
- ld_count  out  CNT_BITS  words written in current/last session
- ram_en  out  1  RAM port access
- ram_we  out  4  per-byte write enable
- ram_addr  out  ADDR_BITS-2  word address
- ram_wdata  out  32  write data
- ram_rdata  in  32  RAM read data, one cycle after ram_en

## Operation
- States: IDLE, DRAIN, LOAD, RELEASE.
- IDLE: cpu_cmd_ready=1, RAM port driven combinationally from CPU. ram_we = mask from size: 0 -> 4'b0001<<addr[1:0], 1 -> 4'b0011<<addr[1:0], 2/3 -> 4'b1111; zero for reads. ld_req=1 -> DRAIN.
- DRAIN: cpu_cmd_ready=0, cpu_hold=1. Stays until no CPU read response is pending (at most one cycle), then -> LOAD. ld_req=0 in DRAIN -> IDLE.
- LOAD: ld_gnt=1, ld_ready=1, cpu_hold=1, RAM driven from loader with ram_we=4'b1111 on writes. Each accepted write increments ld_count, saturating at all-ones. ld_count clears on entry to DRAIN. ld_req=0 -> RELEASE.
- RELEASE: one cycle, no RAM access, ld_gnt=0, cpu_hold=1, then -> IDLE.
- CPU read data returns ram_rdata. CPU write returns no response.
- ld_valid outside LOAD is ignored (ld_ready=0).

## Timing
- Reset values: state IDLE, cpu_cmd_ready=1 (combinational from state), cpu_hold=0, ld_gnt=0, ld_ready=0, cpu_rsp_valid=0, ld_rsp_valid=0, ld_count=0, ram_en=0, ram_we=0.
- cpu_rsp_valid pulses exactly one cycle after an accepted read. ld_rsp_valid behaves the same for loader reads.
- ld_req rise to ld_gnt: 2 cycles (IDLE->DRAIN->LOAD).
- ld_req fall to cpu_cmd_ready: 2 cycles.
- A CPU command presented in the same cycle ld_req rises is still accepted, because IDLE grants the CPU. DRAIN then covers its response.
- Asynchronous reset mid-session: immediate return to IDLE. An in-flight response is dropped.

## Configuration
- MEM_ARB_READBACK_EN defined: in LOAD, ld_wr=0 issues a RAM read, and ld_rsp_valid/ld_rsp_data return it one cycle later.
- Not defined: loader reads are accepted and discarded, no RAM access is made, and ld_rsp_valid/ld_rsp_data are tied to 0.

## Structure
- Shared package holds the state encoding enum (IDLE, DRAIN, LOAD, RELEASE) and the size codes (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2).
- One sub-module, mem_byte_en: combinational size/offset to 4-bit write-mask decoder, reused by the top level.

## Test plan
- CPU byte write to addr 0x006, data 0x00AB0000 -> ram_we=4'b0100, ram_addr=1. Subsequent word read -> cpu_rsp_valid one cycle later with the written lane.
- CPU read in the same cycle ld_req rises -> CPU read accepted, response delivered in DRAIN, ld_gnt high 2 cycles after ld_req.
- Loader writes words 0..9 in LOAD -> ld_count=10, ram_we=4'b1111 each cycle, cpu_cmd_ready=0 throughout. ld_req drop -> cpu_cmd_ready=1 2 cycles later.
- Assert reset_n=0 mid-LOAD -> ld_gnt, cpu_hold, ram_en=0 immediately. After release: IDLE, ld_count=0.
- With MEM_ARB_READBACK_EN, loader read of addr 5 after writing 0xDEADBEEF -> ld_rsp_data=0xDEADBEEF one cycle later. Without the macro -> ld_rsp_valid stays 0 and ram_en=0.
- ld_req pulsed for one cycle -> IDLE->DRAIN->IDLE, ld_gnt never asserts, no RAM access.
